// File: rtl/trace_rx_pkg.sv
// Shared field offsets, default sizing and pointer-width helper for the trace stream receiver.
package trace_rx_pkg;
    localparam int INSTR_WIDTH        = 32;
    localparam int INSTR_LSB          = 0;
    localparam int PC_LSB             = 32;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    // One extra bit beyond the index distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/trace_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
module trace_rx_fifo
    import trace_rx_pkg::*;
#(
    parameter int WIDTH = 97,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] level
);
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;
    assign level     = wr_ptr_r - rd_ptr_r;

    // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r[PTR_W-2:0]] <= push_data;
        end
    end

    // Head entry, forced to zero when nothing is buffered.
    always_comb begin
        pop_data = {WIDTH{1'b0}};
        if (!empty) begin
            pop_data = mem_r[rd_ptr_r[PTR_W-2:0]];
        end else begin
            pop_data = {WIDTH{1'b0}};
        end
    end
endmodule

// File: rtl/trace_stream_receiver.sv
// AXI-Stream sink for {pc, instr} trace beats: buffering, unpacking, tlast framing check and statistics.
module trace_stream_receiver
    import trace_rx_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int AXI_DATA_WIDTH = XLEN + 32,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int CNT_WIDTH      = 32,
    localparam int LVL_W         = ptr_width(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    input  logic                      clear_stats,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [INSTR_WIDTH-1:0]    out_instr,
    output logic                      out_last,
    output logic [LVL_W-1:0]          fifo_level,
    output logic [CNT_WIDTH-1:0]      beat_count,
    output logic [CNT_WIDTH-1:0]      frame_count,
    output logic [CNT_WIDTH-1:0]      tlast_err_count,
    output logic                      tlast_err
);
    localparam int ENT_W = AXI_DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic             rx_enable_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [ENT_W-1:0] head_s;
    logic             accept_s;
    logic             pop_s;
    logic [31:0]      beat_idx_r;
    logic             check_en_s;
    logic             exp_last_s;
    logic             frame_err_s;
    logic [31:0]      idx_next_s;

    assign S_AXIS_tready = rx_enable_r && !fifo_full_s;
    assign accept_s      = S_AXIS_tvalid && S_AXIS_tready;
    assign out_valid     = !fifo_empty_s;
    assign pop_s         = out_valid && out_ready;
    assign out_last      = head_s[AXI_DATA_WIDTH];
    assign out_pc        = head_s[AXI_DATA_WIDTH-1:PC_LSB];
    assign out_instr     = head_s[INSTR_LSB +: INSTR_WIDTH];

    trace_rx_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data ({S_AXIS_tlast, S_AXIS_tdata}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    // Holds tready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_enable_r <= 1'b0;
        end else begin
            rx_enable_r <= 1'b1;
        end
    end

    // Expected-tlast decision for the beat currently on the bus.
    always_comb begin
        check_en_s  = (tlast_interval != 32'd0);
        exp_last_s  = 1'b0;
        frame_err_s = 1'b0;
        idx_next_s  = 32'd0;
        if (check_en_s) begin
            exp_last_s  = (beat_idx_r == (tlast_interval - 32'd1));
            frame_err_s = (S_AXIS_tlast != exp_last_s);
            if (S_AXIS_tlast || exp_last_s) begin
                idx_next_s = 32'd0;
            end else begin
                idx_next_s = beat_idx_r + 32'd1;
            end
        end else begin
            exp_last_s  = 1'b0;
            frame_err_s = 1'b0;
            idx_next_s  = 32'd0;
        end
    end

    // Statistics and frame position; a clear beats a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count      <= {CNT_WIDTH{1'b0}};
            frame_count     <= {CNT_WIDTH{1'b0}};
            tlast_err_count <= {CNT_WIDTH{1'b0}};
            tlast_err       <= 1'b0;
            beat_idx_r      <= 32'd0;
        end else if (clear_stats) begin
            beat_count      <= {CNT_WIDTH{1'b0}};
            frame_count     <= {CNT_WIDTH{1'b0}};
            tlast_err_count <= {CNT_WIDTH{1'b0}};
            tlast_err       <= 1'b0;
            beat_idx_r      <= 32'd0;
        end else if (accept_s) begin
            beat_count <= beat_count + CNT_ONE;
            if (S_AXIS_tlast) begin
                frame_count <= frame_count + CNT_ONE;
            end
            if (frame_err_s) begin
                tlast_err_count <= tlast_err_count + CNT_ONE;
                tlast_err       <= 1'b1;
            end
            beat_idx_r <= idx_next_s;
        end
    end
endmodule

// File: tb/tb_trace_stream_receiver.sv
// Directed bench for trace_stream_receiver with a queue-based reference model checked every cycle.
module tb_trace_stream_receiver;
    localparam int XLEN  = 64;
    localparam int AW    = 96;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [AW-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic [31:0]   interval = 32'd0;
    logic          clear_stats = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_last;
    logic [LW-1:0] fifo_level;
    logic [CW-1:0] beat_count, frame_count, tlast_err_count;
    logic          tlast_err;

    always #5 clk = ~clk;

    trace_stream_receiver #(
        .XLEN(XLEN), .AXI_DATA_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready), .S_AXIS_tdata(tdata), .S_AXIS_tlast(tlast),
        .tlast_interval(interval), .clear_stats(clear_stats),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_last(out_last), .fifo_level(fifo_level), .beat_count(beat_count),
        .frame_count(frame_count), .tlast_err_count(tlast_err_count), .tlast_err(tlast_err)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: buffered beats as a queue plus plain statistics.
    typedef struct { logic [63:0] pc; logic [31:0] instr; logic last; } ent_t;
    ent_t        mq[$];
    int unsigned m_beats, m_frames, m_errs, m_pos;
    bit          m_err, m_en;
    logic [63:0] got_pc[$];
    bit          got_last[$];

    always @(negedge clk) begin : compare
        bit   acc_b, pop_b, boundary;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_beats = 0; m_frames = 0; m_errs = 0; m_pos = 0; m_err = 0; m_en = 0;
        end
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_last", out_last, mq[0].last);
        end else begin
            chk("out_pc_idle", out_pc, 64'd0);
            chk("out_instr_idle", out_instr, 32'd0);
            chk("out_last_idle", out_last, 1'b0);
        end
        chk("fifo_level", fifo_level, mq.size());
        chk("tready", tready, m_en && mq.size() < DEPTH);
        chk("beat_count", beat_count, m_beats);
        chk("frame_count", frame_count, m_frames);
        chk("tlast_err_count", tlast_err_count, m_errs);
        chk("tlast_err", tlast_err, m_err);
        if (!rst) begin
            acc_b = tvalid && m_en && (mq.size() < DEPTH);
            pop_b = (mq.size() != 0) && out_ready;
            if (pop_b) begin
                got_pc.push_back(out_pc);
                got_last.push_back(out_last);
            end
            if (clear_stats) begin
                m_beats = 0; m_frames = 0; m_errs = 0; m_pos = 0; m_err = 0;
            end else if (acc_b) begin
                m_beats++;
                if (tlast) m_frames++;
                if (interval == 32'd0) begin
                    m_pos = 0;
                end else begin
                    boundary = (m_pos + 1 == interval);
                    if (tlast != boundary) begin
                        m_errs++;
                        m_err = 1;
                    end
                    m_pos = (tlast || boundary) ? 0 : m_pos + 1;
                end
            end
            if (pop_b) void'(mq.pop_front());
            if (acc_b) begin
                e.pc = tdata[95:32]; e.instr = tdata[31:0]; e.last = tlast;
                mq.push_back(e);
            end
            m_en = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] ins, input logic last);
        bit done = 0;
        tdata = {pc, ins};
        tlast = last;
        tvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            done = tready;
            tick();
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL offer_timeout: got no accept expected accept within 64 cycles");
        end
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (out_valid && k < 64) begin
            tick();
            k++;
        end
        if (out_valid) begin
            n_total++;
            $display("FAIL drain_timeout: got out_valid=1 expected empty within 64 cycles");
        end
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    int ones;

    initial begin
        repeat (3) tick();
        chk("rst_tready", tready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_tready", tready, 1'b1);

        // Basic frame of four beats
        interval = 32'd4;
        out_ready = 1'b1;
        got_pc.delete(); got_last.delete();
        for (int i = 0; i < 4; i++) offer(64'h1000 + 64'(4 * i), 32'h13, i == 3);
        drain();
        chk("t1_npop", got_pc.size(), 4);
        chk("t1_pc0", got_pc[0], 64'h1000);
        chk("t1_pc1", got_pc[1], 64'h1004);
        chk("t1_pc2", got_pc[2], 64'h1008);
        chk("t1_pc3", got_pc[3], 64'h100C);
        chk("t1_last2", got_last[2], 1'b0);
        chk("t1_last3", got_last[3], 1'b1);
        chk("t1_beats", beat_count, 32'd4);
        chk("t1_frames", frame_count, 32'd1);
        chk("t1_err", tlast_err, 1'b0);

        // Back-pressure: fill to 16, free one slot, then continue
        out_ready = 1'b0;
        got_pc.delete(); got_last.delete();
        for (int i = 0; i < 16; i++) offer(64'h2000 + 64'(4 * i), 32'h13 + 32'(i), (i % 4) == 3);
        chk("t2_full_tready", tready, 1'b0);
        chk("t2_full_level", fifo_level, 5'd16);
        tdata = {64'h2040, 32'h13 + 32'd16};
        tvalid = 1'b1;
        tick();
        chk("t2_hold_tready", tready, 1'b0);
        chk("t2_hold_level", fifo_level, 5'd16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_reopen_tready", tready, 1'b1);
        chk("t2_reopen_level", fifo_level, 5'd15);
        offer(64'h2040, 32'h13 + 32'd16, 1'b0);
        chk("t2_refill_level", fifo_level, 5'd16);
        out_ready = 1'b1;
        for (int i = 17; i < 20; i++) offer(64'h2000 + 64'(4 * i), 32'h13 + 32'(i), (i % 4) == 3);
        drain();
        chk("t2_npop", got_pc.size(), 20);
        for (int i = 0; i < 20; i++) chk("t2_order", got_pc[i], 64'h2000 + 64'(4 * i));
        chk("t2_errs", tlast_err_count, 32'd0);

        // Early tlast, then a clean frame
        pulse_clear();
        offer(64'h3000, 32'h1, 1'b0);
        offer(64'h3004, 32'h2, 1'b1);
        for (int i = 0; i < 4; i++) offer(64'h3008 + 64'(4 * i), 32'h3, i == 3);
        drain();
        chk("t3_errs", tlast_err_count, 32'd1);
        chk("t3_err", tlast_err, 1'b1);
        chk("t3_frames", frame_count, 32'd2);
        chk("t3_beats", beat_count, 32'd6);

        // Missing tlast resyncs, following frame is clean
        pulse_clear();
        for (int i = 0; i < 4; i++) offer(64'h4000 + 64'(4 * i), 32'h4, 1'b0);
        for (int i = 0; i < 4; i++) offer(64'h4010 + 64'(4 * i), 32'h5, i == 3);
        drain();
        chk("t4_errs", tlast_err_count, 32'd1);
        chk("t4_frames", frame_count, 32'd1);
        chk("t4_beats", beat_count, 32'd8);

        // Framing check disabled
        pulse_clear();
        interval = 32'd0;
        ones = 0;
        for (int i = 0; i < 50; i++) begin
            logic l;
            l = 1'($urandom_range(0, 1));
            if (l) ones++;
            offer(64'h5000 + 64'(4 * i), 32'h6, l);
        end
        drain();
        chk("t5_errs", tlast_err_count, 32'd0);
        chk("t5_err", tlast_err, 1'b0);
        chk("t5_frames", frame_count, ones);
        chk("t5_beats", beat_count, 32'd50);

        // Reset with entries buffered
        interval = 32'd4;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) offer(64'h6000 + 64'(4 * i), 32'h7, 1'b0);
        chk("t6_level7", fifo_level, 5'd7);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_level", fifo_level, 5'd0);
        chk("t6_rst_tready", tready, 1'b0);
        chk("t6_rst_beats", beat_count, 32'd0);
        chk("t6_rst_errs", tlast_err_count, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t6_rel_tready", tready, 1'b1);
        chk("t6_rel_valid", out_valid, 1'b0);

        // Clear in the same cycle as an accept
        clear_stats = 1'b1;
        offer(64'hDEAD_BEEF_0000_0040, 32'h73, 1'b1);
        clear_stats = 1'b0;
        chk("t7_beats", beat_count, 32'd0);
        chk("t7_frames", frame_count, 32'd0);
        chk("t7_errs", tlast_err_count, 32'd0);
        chk("t7_valid", out_valid, 1'b1);
        chk("t7_pc", out_pc, 64'hDEAD_BEEF_0000_0040);
        chk("t7_instr", out_instr, 32'h73);
        chk("t7_last", out_last, 1'b1);
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
